// File: rtl/ula_control_seq_if.sv
// Handshake and decode bus between the main control FSM and the ALU-control sequencer.
interface ula_control_seq_if #(
  parameter int unsigned SEL_W = 3
);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [SEL_W-1:0] seletor;
  logic             md_start;
  logic             md_op;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, opcode, funct,
    input  seletor, md_start, md_op, busy, done, illegal
  );

  modport slave (
    input  start, opcode, funct,
    output seletor, md_start, md_op, busy, done, illegal
  );
endinterface

// File: rtl/ula_control_seq.sv
// Registered ALU-control decoder that also sequences multi-cycle mult/div
// operations with a busy/done handshake toward the control FSM.
module ula_control_seq #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset,
  ula_control_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

  typedef enum logic [0:0] {
    IDLE,
    MD_RUN
  } state_t;

  typedef enum logic [1:0] {
    D_SIMPLE,
    D_ILLEGAL,
    D_MULDIV
  } dec_kind_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             md_start_q, md_start_d;
  logic             md_op_q, md_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  dec_kind_t        dec_kind;
  logic [2:0]       dec_code;
  logic             accept;
  logic             last_md_cycle;

  // Opcode 0x00 is the R-type group and is resolved through funct.
  always_comb begin
    dec_kind = D_ILLEGAL;
    dec_code = 3'b000;
    if (bus.opcode == 6'h00) begin
      unique case (bus.funct)
        6'h20, 6'h0d, 6'h13: begin dec_kind = D_SIMPLE; dec_code = 3'b001; end
        6'h22:               begin dec_kind = D_SIMPLE; dec_code = 3'b010; end
        6'h24:               begin dec_kind = D_SIMPLE; dec_code = 3'b011; end
        6'h2a:               begin dec_kind = D_SIMPLE; dec_code = 3'b111; end
        6'h08, 6'h10, 6'h12: begin dec_kind = D_SIMPLE; dec_code = 3'b000; end
        6'h18, 6'h1a:        begin dec_kind = D_MULDIV; dec_code = 3'b000; end
        default:             begin dec_kind = D_ILLEGAL; dec_code = 3'b000; end
      endcase
    end else begin
      unique case (bus.opcode)
        6'h08, 6'h09, 6'h20, 6'h21,
        6'h23, 6'h28, 6'h29, 6'h2b:  begin dec_kind = D_SIMPLE; dec_code = 3'b001; end
        6'h04:                       begin dec_kind = D_SIMPLE; dec_code = 3'b010; end
        6'h05, 6'h06, 6'h07, 6'h0a:  begin dec_kind = D_SIMPLE; dec_code = 3'b111; end
        6'h0f:                       begin dec_kind = D_SIMPLE; dec_code = 3'b000; end
        default:                     begin dec_kind = D_ILLEGAL; dec_code = 3'b000; end
      endcase
    end
  end

  assign accept        = bus.start && (state_q == IDLE);
  assign last_md_cycle = (state_q == MD_RUN) && (cnt_q == CNT_W'(1));

  // State and output registers; reset abandons any in-flight mult/div silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (dec_kind == D_MULDIV)) begin
          state_d = MD_RUN;
          cnt_d   = CNT_W'(MD_CYCLES);
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_md_cycle) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Computes the next value of every registered output; selector, md_op and
  // illegal hold unless explicitly updated.
  always_comb begin
    sel_d      = sel_q;
    md_op_d    = md_op_q;
    illegal_d  = illegal_q;
    md_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (dec_kind)
            D_SIMPLE: begin
              sel_d     = SEL_W'(dec_code);
              illegal_d = 1'b0;
              done_d    = 1'b1;
            end
            D_MULDIV: begin
              sel_d      = '0;
              md_op_d    = bus.funct[1];
              md_start_d = 1'b1;
              busy_d     = 1'b1;
            end
            default: begin
              sel_d     = '0;
              illegal_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end
      MD_RUN: begin
        busy_d = !last_md_cycle;
        if (last_md_cycle) begin
          done_d    = 1'b1;
          illegal_d = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.seletor  = sel_q;
  assign bus.md_start = md_start_q;
  assign bus.md_op    = md_op_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;

  a_md_start_single: assert property (@(posedge clock) disable iff (reset)
    md_start_q |=> !md_start_q);

  a_busy_matches_state: assert property (@(posedge clock) disable iff (reset)
    busy_q == (state_q == MD_RUN));

  a_cnt_in_range: assert property (@(posedge clock) disable iff (reset)
    cnt_q <= CNT_W'(MD_CYCLES));

endmodule

// File: tb/tb_ula_control_seq.sv
// Scoreboard bench for ula_control_seq: table-driven reference decode plus
// a timeline model of the busy window, checked by an independent monitor.
module tb_ula_control_seq;
  localparam int unsigned SEL_W = 5;
  localparam int          MD    = 4;

  logic clock = 1'b0;
  logic reset;

  ula_control_seq_if #(.SEL_W(SEL_W)) bus ();

  ula_control_seq #(.SEL_W(SEL_W), .MD_CYCLES(MD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               at;
    logic [SEL_W-1:0] sel;
    logic             ill;
  } done_exp_t;

  typedef struct {
    int   at;
    logic op;
  } md_exp_t;

  done_exp_t dq[$];
  md_exp_t   mq[$];

  int tests    = 0;
  int fails    = 0;
  int edge_no  = 0;
  int md_n     = -1000;

  logic [SEL_W-1:0] held_sel = '0;
  logic             held_ill = 1'b0;
  logic             held_op  = 1'b0;

  // Reference decode tables: value 8 marks a mult/div request.
  int funct_code[int];
  int opcode_code[int];

  function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endfunction

  function automatic bit busy_at(int obs);
    return (obs >= md_n) && (obs < md_n + MD);
  endfunction

  task automatic drive(input bit s, input bit r, input logic [5:0] op, input logic [5:0] fn);
    int n;
    int code;
    @(negedge clock);
    reset      = r;
    bus.start  = s;
    bus.opcode = op;
    bus.funct  = fn;
    n = edge_no + 1;
    if (r) begin
      dq.delete();
      mq.delete();
      held_sel = '0;
      held_ill = 1'b0;
      held_op  = 1'b0;
      md_n     = -1000;
    end else if (s && !busy_at(n - 1)) begin
      if (op == 6'h00) code = funct_code.exists(int'(fn)) ? funct_code[int'(fn)] : -1;
      else             code = opcode_code.exists(int'(op)) ? opcode_code[int'(op)] : -1;
      if (code < 0) begin
        dq.push_back('{at: n, sel: '0, ill: 1'b1});
      end else if (code == 8) begin
        mq.push_back('{at: n, op: fn[1]});
        dq.push_back('{at: n + MD, sel: '0, ill: 1'b0});
        md_n = n;
      end else begin
        dq.push_back('{at: n, sel: SEL_W'(code), ill: 1'b0});
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 6'h00, 6'h00);
  endtask

  // Monitor: outputs observed just after edge e reflect starts sampled at edge e.
  initial begin
    done_exp_t de;
    md_exp_t   me;
    forever begin
      @(posedge clock);
      edge_no++;
      #1;
      if (bus.md_start) begin
        check_eq("md_start_expected", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) begin
          me = mq.pop_front();
          check_eq("md_start_time", 32'(edge_no), 32'(me.at));
          check_eq("md_op", 32'(bus.md_op), 32'(me.op));
          held_op  = me.op;
          held_sel = '0;
        end
      end else if (mq.size() != 0 && mq[0].at <= edge_no) begin
        check_eq("md_start_missing", 32'(bus.md_start), 32'd1);
        void'(mq.pop_front());
      end
      if (bus.done) begin
        check_eq("done_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          de = dq.pop_front();
          check_eq("done_time", 32'(edge_no), 32'(de.at));
          check_eq("seletor", 32'(bus.seletor), 32'(de.sel));
          check_eq("illegal", 32'(bus.illegal), 32'(de.ill));
          held_sel = de.sel;
          held_ill = de.ill;
        end
      end else if (dq.size() != 0 && dq[0].at <= edge_no) begin
        check_eq("done_missing", 32'(bus.done), 32'd1);
        void'(dq.pop_front());
      end
      check_eq("busy_sel_op_ill",
               32'({bus.busy, bus.seletor, bus.md_op, bus.illegal}),
               32'({busy_at(edge_no), held_sel, held_op, held_ill}));
    end
  end

  initial begin
    int legal_ops[$];
    int r;
    int pick;
    legal_ops = '{'h08, 'h09, 'h20, 'h21, 'h23, 'h28, 'h29, 'h2b, 'h04, 'h05, 'h06, 'h07, 'h0a, 'h0f};
    foreach (legal_ops[i]) opcode_code[legal_ops[i]] = 1;
    opcode_code['h04] = 2;
    opcode_code['h05] = 7; opcode_code['h06] = 7; opcode_code['h07] = 7; opcode_code['h0a] = 7;
    opcode_code['h0f] = 0;
    funct_code['h20] = 1; funct_code['h0d] = 1; funct_code['h13] = 1;
    funct_code['h22] = 2; funct_code['h24] = 3; funct_code['h2a] = 7;
    funct_code['h08] = 0; funct_code['h10] = 0; funct_code['h12] = 0;
    funct_code['h18] = 8; funct_code['h1a] = 8;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    drive(1'b0, 1'b1, 6'h00, 6'h00);
    drive(1'b0, 1'b1, 6'h00, 6'h00);
    idle(2);

    // Back-to-back simple ops: sub, sw, bne.
    drive(1'b1, 1'b0, 6'h00, 6'h22);
    drive(1'b1, 1'b0, 6'h2b, 6'h00);
    drive(1'b1, 1'b0, 6'h05, 6'h00);
    idle(2);

    // Illegal opcode then illegal funct.
    drive(1'b1, 1'b0, 6'h3f, 6'h00);
    idle(1);
    drive(1'b1, 1'b0, 6'h00, 6'h3f);
    idle(2);

    // Mult, then a start in the done cycle's closing edge.
    drive(1'b1, 1'b0, 6'h00, 6'h18);
    idle(MD);
    drive(1'b1, 1'b0, 6'h00, 6'h2a);
    idle(2);

    // Div with an add pulsed two edges later (must be ignored).
    drive(1'b1, 1'b0, 6'h00, 6'h1a);
    idle(1);
    drive(1'b1, 1'b0, 6'h00, 6'h20);
    idle(MD + 2);

    // Reset in the middle of a mult: no done may follow.
    drive(1'b1, 1'b0, 6'h00, 6'h18);
    idle(1);
    drive(1'b0, 1'b1, 6'h00, 6'h00);
    idle(MD + 3);

    // slt exercises the zero-extension into the wider selector.
    drive(1'b1, 1'b0, 6'h00, 6'h2a);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      pick = $urandom_range(0, 9);
      if (r < 2) begin
        drive(1'b0, 1'b1, 6'h00, 6'h00);
      end else if (r < 65) begin
        if (pick < 4)
          drive(1'b1, 1'b0, 6'(legal_ops[$urandom_range(0, legal_ops.size() - 1)]), 6'($urandom));
        else if (pick < 8)
          drive(1'b1, 1'b0, 6'h00, 6'($urandom));
        else if (pick < 9)
          drive(1'b1, 1'b0, 6'h00, ($urandom_range(0, 1) != 0) ? 6'h18 : 6'h1a);
        else
          drive(1'b1, 1'b0, 6'($urandom), 6'($urandom));
      end else begin
        drive(1'b0, 1'b0, 6'($urandom), 6'($urandom));
      end
    end

    idle(MD + 3);
    @(negedge clock);
    check_eq("drain_done_queue", 32'(dq.size()), 32'd0);
    check_eq("drain_md_queue", 32'(mq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
